poly_tobytes_packer: RTL and testbench

- Streaming stage directly downstream of the signed Barrett reduction.
- Consumes one reduced signed 16-bit coefficient per handshake and freezes it to the canonical range [0, KYBER_Q-1].
- Packs each coefficient pair into three bytes, in Kyber poly_tobytes order.
- Emits a byte stream with valid/ready handshake and frame-end marker: NCOEF coefficients in, NCOEF*3/2 bytes out (256 -> 384).

---
 rtl/poly_tobytes_packer_if.sv | 33 +++
 rtl/poly_tobytes_packer.sv | 170 +++++++++++++++++
 tb/tb_poly_tobytes_packer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_tobytes_packer_if.sv
// -----------------------------------------------------------------------------
// poly_tobytes_packer_if
// Purpose : Bundles the coefficient input stream, the packed byte output stream
//           and the sticky error flag of the poly_tobytes packer.
// Signals : in_valid/in_ready/in_coef   - signed coefficient stream (upstream)
//           out_valid/out_ready/out_byte - packed byte stream (downstream)
//           out_last                     - marks the final byte of a frame
//           coef_err                     - sticky out-of-range coefficient flag
// Modports: slave  - the packer itself
//           master - the environment driving coefficients and taking bytes
// -----------------------------------------------------------------------------
interface poly_tobytes_packer_if #(
    parameter int COEF_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic              out_last;
    logic              coef_err;

    modport slave (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_byte, out_last, coef_err
    );

    modport master (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_byte, out_last, coef_err
    );
endinterface

// File: rtl/poly_tobytes_packer.sv
// -----------------------------------------------------------------------------
// poly_tobytes_packer
// Purpose : Takes signed, Barrett-reduced coefficients one per handshake,
//           freezes each into [0, KYBER_Q-1] and packs every pair (a0, a1)
//           into three bytes in Kyber poly_tobytes order:
//              byte0 = a0[7:0], byte1 = {a1[3:0], a0[11:8]}, byte2 = a1[11:4]
//           NCOEF coefficients form one frame of NCOEF*3/2 bytes; out_last
//           flags the frame's final byte.
// Ports   : clk  - clock, all state on rising edge
//           rst  - asynchronous active-high reset
//           bus  - poly_tobytes_packer_if.slave (coefficient in, byte out,
//                  out_last, sticky coef_err)
// -----------------------------------------------------------------------------
module poly_tobytes_packer #(
    parameter int KYBER_Q = 3329,
    parameter int NCOEF   = 256,
    parameter int COEF_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    poly_tobytes_packer_if.slave bus
);
    localparam int PAIRS = NCOEF / 2;
    localparam int CNT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int EXT_W = COEF_W + 2;

    localparam logic [CNT_W-1:0]        LAST_PAIR = CNT_W'(PAIRS - 1);
    localparam logic signed [EXT_W-1:0] Q_EXT     = EXT_W'(KYBER_Q);
    localparam logic signed [EXT_W-1:0] LO_EXT    = EXT_W'(-(KYBER_Q - 1));
    localparam logic signed [EXT_W-1:0] HI_EXT    = EXT_W'(2 * KYBER_Q - 1);

    typedef enum logic [2:0] {
        S_A0,
        S_A1,
        S_B0,
        S_B1,
        S_B2
    } state_t;

    state_t                  state_q, state_d;
    logic [11:0]             a0_q, a0_d;
    logic [11:0]             a1_q, a1_d;
    logic [CNT_W-1:0]        pairCount_q, pairCount_d;
    logic                    outValid_q, outValid_d;
    logic [7:0]              outByte_q, outByte_d;
    logic                    outLast_q, outLast_d;
    logic                    coefErr_q, coefErr_d;

    logic signed [EXT_W-1:0] coefExt;
    logic signed [EXT_W-1:0] frozenFull;
    logic [11:0]             frozen;
    logic                    coefOutOfRange;
    logic                    unusedFrozenHi;
    logic                    inReady;
    logic                    inFire;
    logic                    outFire;

    // Freeze: one conditional add or subtract of Q brings any legal reduced
    // value into [0, Q-1]. The input is widened by two bits so neither the
    // add nor the subtract can overflow. Out-of-range inputs still produce
    // the low 12 bits of the same arithmetic; only the error flag differs.
    always_comb begin
        coefExt = {{2{bus.in_coef[COEF_W-1]}}, bus.in_coef};
        if (coefExt[EXT_W-1]) begin
            frozenFull = coefExt + Q_EXT;
        end else if (coefExt >= Q_EXT) begin
            frozenFull = coefExt - Q_EXT;
        end else begin
            frozenFull = coefExt;
        end
        coefOutOfRange = (coefExt < LO_EXT) || (coefExt > HI_EXT);
    end

    assign frozen         = frozenFull[11:0];
    assign unusedFrozenHi = ^frozenFull[EXT_W-1:12];

    // Input is only taken while collecting a pair; once bytes are pending the
    // upstream is stalled until the third byte has gone out.
    assign inReady = (state_q == S_A0) || (state_q == S_A1);
    assign inFire  = bus.in_valid && inReady;
    assign outFire = outValid_q && bus.out_ready;

    // Next-state logic. The byte outputs are registered, so each state loads
    // the byte that becomes visible in the *following* state: accepting a1
    // preloads byte0, and every byte transfer preloads the next byte. Without
    // a transfer nothing moves, which keeps outputs stable under backpressure.
    always_comb begin
        state_d     = state_q;
        a0_d        = a0_q;
        a1_d        = a1_q;
        pairCount_d = pairCount_q;
        outValid_d  = outValid_q;
        outByte_d   = outByte_q;
        outLast_d   = outLast_q;
        coefErr_d   = coefErr_q | (inFire & coefOutOfRange);

        case (state_q)
            S_A0: begin
                if (inFire) begin
                    a0_d    = frozen;
                    state_d = S_A1;
                end
            end
            S_A1: begin
                if (inFire) begin
                    a1_d       = frozen;
                    outValid_d = 1'b1;
                    outByte_d  = a0_q[7:0];
                    outLast_d  = 1'b0;
                    state_d    = S_B0;
                end
            end
            S_B0: begin
                if (outFire) begin
                    outByte_d = {a1_q[3:0], a0_q[11:8]};
                    state_d   = S_B1;
                end
            end
            S_B1: begin
                if (outFire) begin
                    outByte_d = a1_q[11:4];
                    outLast_d = (pairCount_q == LAST_PAIR);
                    state_d   = S_B2;
                end
            end
            S_B2: begin
                if (outFire) begin
                    outValid_d  = 1'b0;
                    outByte_d   = 8'h00;
                    outLast_d   = 1'b0;
                    pairCount_d = (pairCount_q == LAST_PAIR) ? '0 : pairCount_q + 1'b1;
                    state_d     = S_A0;
                end
            end
            default: begin
                state_d = S_A0;
            end
        endcase
    end

    // State and datapath registers. Reset discards any partial pair and any
    // pending bytes and restarts the frame count at pair 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_A0;
            a0_q        <= '0;
            a1_q        <= '0;
            pairCount_q <= '0;
            outValid_q  <= 1'b0;
            outByte_q   <= 8'h00;
            outLast_q   <= 1'b0;
            coefErr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            pairCount_q <= pairCount_d;
            outValid_q  <= outValid_d;
            outByte_q   <= outByte_d;
            outLast_q   <= outLast_d;
            coefErr_q   <= coefErr_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid_q;
    assign bus.out_byte  = outByte_q;
    assign bus.out_last  = outLast_q;
    assign bus.coef_err  = coefErr_q;
endmodule

// File: tb/tb_poly_tobytes_packer.sv
// -----------------------------------------------------------------------------
// tb_poly_tobytes_packer
// Purpose : Directed bench for poly_tobytes_packer: reset values, freeze cases,
//           first-byte latency, backpressure, the sticky error flag, reset in
//           the middle of a frame and two back-to-back full frames under random
//           in_valid gaps and random out_ready.
// -----------------------------------------------------------------------------
module tb_poly_tobytes_packer;
    localparam int COEF_W      = 16;
    localparam int NCOEF       = 256;
    localparam int FRAME_BYTES = NCOEF * 3 / 2;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         stamp;
    } byte_rec_t;

    logic      clk = 1'b0;
    logic      rst;
    byte_rec_t rxQ[$];
    int        cycleCount = 0;
    int        checkCount = 0;
    int        errorCount = 0;
    bit        stopRandom = 1'b0;

    poly_tobytes_packer_if #(.COEF_W(COEF_W)) bus ();

    poly_tobytes_packer #(
        .KYBER_Q (3329),
        .NCOEF   (NCOEF),
        .COEF_W  (COEF_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp received bytes.
    always @(posedge clk) begin
        cycleCount++;
    end

    // Output monitor: inputs only change just after a rising edge, so the
    // values seen on the falling edge are exactly what the next edge transfers.
    always @(negedge clk) begin
        byte_rec_t rec;
        if (!rst && bus.out_valid && bus.out_ready) begin
            rec.data  = bus.out_byte;
            rec.last  = bus.out_last;
            rec.stamp = cycleCount;
            rxQ.push_back(rec);
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one coefficient and holds it until accepted (bounded wait).
    // Called and returns just after a rising edge.
    task automatic applyStimulus(input int coef);
        int  waited;
        bit  done;
        waited       = 0;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_coef  = 16'(coef);
        while (!done && waited < 200) begin
            @(negedge clk);
            if (bus.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 32'(0), 32'(1));
    endtask

    // Waits for at least n received bytes (bounded wait).
    task automatic waitBytes(input int n, input int bound);
        int waited;
        waited = 0;
        while (rxQ.size() < n && waited < bound) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (rxQ.size() < n) checkOutput("byteTimeout", 32'(rxQ.size()), 32'(n));
    endtask

    // Pops three bytes and compares them with hand-computed values.
    task automatic checkTriple(input string tag, input logic [7:0] e0,
                               input logic [7:0] e1, input logic [7:0] e2);
        byte_rec_t r0, r1, r2;
        waitBytes(3, 100);
        if (rxQ.size() >= 3) begin
            r0 = rxQ.pop_front();
            r1 = rxQ.pop_front();
            r2 = rxQ.pop_front();
            checkOutput({tag, "_b0"}, 32'(r0.data), 32'(e0));
            checkOutput({tag, "_b1"}, 32'(r1.data), 32'(e1));
            checkOutput({tag, "_b2"}, 32'(r2.data), 32'(e2));
            checkOutput({tag, "_last"}, 32'({r0.last, r1.last, r2.last}), 32'(0));
        end
    endtask

    // Software poly_tobytes on the frame of coefficients i mod 3329.
    function automatic logic [7:0] modelByte(input int idx);
        int k, t0, t1;
        k  = idx % FRAME_BYTES;
        t0 = (2 * (k / 3)) % 3329;
        t1 = (2 * (k / 3) + 1) % 3329;
        case (k % 3)
            0:       return 8'(t0 >> 0);
            1:       return 8'((t0 >> 8) | (t1 << 4));
            default: return 8'(t1 >> 4);
        endcase
    endfunction

    // Main sequence.
    initial begin
        byte_rec_t r0, r1, r2, rec;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.out_ready = 1'b1;
        #2;
        checkOutput("rstInReady", 32'(bus.in_ready), 32'(1));
        checkOutput("rstOutValid", 32'(bus.out_valid), 32'(0));
        checkOutput("rstOutByte", 32'(bus.out_byte), 32'(0));
        checkOutput("rstOutLast", 32'(bus.out_last), 32'(0));
        checkOutput("rstCoefErr", 32'(bus.coef_err), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pair 0: 1, 2 -> latency and back-to-back byte timing.
        applyStimulus(1);
        checkOutput("t1ValidBeforeA1", 32'(bus.out_valid), 32'(0));
        applyStimulus(2);
        checkOutput("t1Latency", 32'(bus.out_valid), 32'(1));
        checkOutput("t1InReadyLow", 32'(bus.in_ready), 32'(0));
        waitBytes(3, 100);
        if (rxQ.size() >= 3) begin
            r0 = rxQ.pop_front();
            r1 = rxQ.pop_front();
            r2 = rxQ.pop_front();
            checkOutput("t1_b0", 32'(r0.data), 32'h01);
            checkOutput("t1_b1", 32'(r1.data), 32'h20);
            checkOutput("t1_b2", 32'(r2.data), 32'h00);
            checkOutput("t1_last", 32'({r0.last, r1.last, r2.last}), 32'(0));
            checkOutput("t1Spacing01", 32'(r1.stamp - r0.stamp), 32'(1));
            checkOutput("t1Spacing12", 32'(r2.stamp - r1.stamp), 32'(1));
        end
        checkOutput("t1CoefErr", 32'(bus.coef_err), 32'(0));

        // 3328 = 0xD00, 2748 = 0xABC.
        applyStimulus(3328);
        applyStimulus(2748);
        checkTriple("t2", 8'h00, 8'hCD, 8'hAB);

        // -1 -> 3328 (0xD00), 3329 -> 0.
        applyStimulus(-1);
        applyStimulus(3329);
        checkTriple("t3", 8'h00, 8'h0D, 8'h00);

        // 6657 -> 3328 (0xD00), -3328 -> 1: byte1 = {1, D}.
        applyStimulus(6657);
        applyStimulus(-3328);
        checkTriple("t4", 8'h00, 8'h1D, 8'h00);
        checkOutput("t4CoefErr", 32'(bus.coef_err), 32'(0));

        // Backpressure on byte1 for four cycles.
        applyStimulus(3328);
        applyStimulus(2748);
        checkOutput("bpByte0", 32'(bus.out_byte), 32'h00);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bpHoldByte", 32'(bus.out_byte), 32'hCD);
            checkOutput("bpHoldValid", 32'(bus.out_valid), 32'(1));
            checkOutput("bpHoldInReady", 32'(bus.in_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        checkTriple("bp", 8'h00, 8'hCD, 8'hAB);

        // Out-of-range coefficient sets the sticky flag; reset clears it.
        applyStimulus(-3329);
        checkOutput("errSet", 32'(bus.coef_err), 32'(1));
        applyStimulus(5);
        checkTriple("err", 8'h00, 8'h50, 8'h00);
        applyStimulus(7);
        checkOutput("errSticky", 32'(bus.coef_err), 32'(1));
        rst = 1'b1;
        #1;
        checkOutput("midRstInReady", 32'(bus.in_ready), 32'(1));
        checkOutput("midRstOutValid", 32'(bus.out_valid), 32'(0));
        checkOutput("midRstOutByte", 32'(bus.out_byte), 32'(0));
        checkOutput("midRstOutLast", 32'(bus.out_last), 32'(0));
        checkOutput("midRstCoefErr", 32'(bus.coef_err), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        rxQ.delete();
        @(posedge clk);
        #1;

        // Two back-to-back frames with random gaps and random out_ready.
        fork
            begin
                while (!stopRandom) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < NCOEF; i++) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                applyStimulus(i % 3329);
            end
        end
        waitBytes(2 * FRAME_BYTES, 20000);
        stopRandom = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("frameByteCount", 32'(rxQ.size()), 32'(2 * FRAME_BYTES));
        for (int k = 0; k < rxQ.size() && k < 2 * FRAME_BYTES; k++) begin
            rec = rxQ[k];
            checkOutput($sformatf("frameByte%0d", k), 32'(rec.data), 32'(modelByte(k)));
            checkOutput($sformatf("frameLast%0d", k), 32'(rec.last),
                        32'((k % FRAME_BYTES) == FRAME_BYTES - 1));
        end
        checkOutput("frameCoefErr", 32'(bus.coef_err), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
